// File: rtl/bram_port_ctrl_pkg.sv
// bram_port_ctrl_pkg
// Shared constants and types for the BRAM port request front end.
//   DEFAULT_DATA / DEFAULT_ADDR : default word and address widths, also used
//                                 by the bram_tdp test wrappers
//   RSP_DEPTH                   : response FIFO entries
//   CNT_W                       : width of a 0..RSP_DEPTH occupancy count
//   state_t                     : controller FSM states
`timescale 1ns/1ps
package bram_port_ctrl_pkg;

    localparam int DEFAULT_DATA = 72;
    localparam int DEFAULT_ADDR = 10;
    localparam int RSP_DEPTH    = 4;
    localparam int CNT_W        = $clog2(RSP_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,   // zero-filling the memory
        ST_RUN   = 2'd1,   // accepting requests
        ST_DRAIN = 2'd2    // waiting for in-flight reads before refilling
    } state_t;

endpackage

// File: rtl/bram_port_ctrl_rsp_fifo.sv
// rsp_fifo
// Small synchronous FIFO holding read responses.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data this cycle (must not be full)
//   push_data   : data to enqueue
//   pop         : remove the head entry this cycle (ignored when empty)
//   count       : current occupancy, 0..RSP_DEPTH
//   head_data   : registered copy of the oldest entry
`timescale 1ns/1ps
module rsp_fifo
    import bram_port_ctrl_pkg::*;
#(
    parameter int DATA = DEFAULT_DATA
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DATA-1:0]  push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [DATA-1:0]  head_data
);

    localparam int PTR_W = $clog2(RSP_DEPTH);

    logic [DATA-1:0]  mem_reg [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_reg;
    logic [DATA-1:0]  head_reg;
    logic             pop_ok;

    assign pop_ok     = pop && (count_reg != '0);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign count      = count_reg;
    assign head_data  = head_reg;

    // Storage carries no reset; only pointers, count and head are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            assert (!(push && count_reg == CNT_W'(RSP_DEPTH)));
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({push, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // The head register must show the oldest entry. New data goes
            // straight to the head when the FIFO is (or is becoming) empty;
            // otherwise a pop advances the head to the next stored entry.
            if (push && (count_reg == '0 || (pop_ok && count_reg == CNT_W'(1)))) begin
                head_reg <= push_data;
            end else if (pop_ok && count_reg > CNT_W'(1)) begin
                head_reg <= mem_reg[rd_ptr_inc];
            end
        end
    end

endmodule

// File: rtl/bram_port_ctrl.sv
// bram_port_ctrl
// Request front end for one port of a true-dual-port BRAM. Accepts read and
// write requests over valid/ready, drives the BRAM port with registered
// signals, buffers read data in a response FIFO, and zero-fills the memory
// after reset or on a clr pulse.
//   clk, rst_n              : clock, asynchronous active-low reset
//   clr                     : pulse requesting a zero-fill (honoured in RUN)
//   init_busy               : high while draining or zero-filling
//   req_valid/ready/wr/addr/wdata : request channel
//   rsp_valid/ready/rdata   : response channel, read data in request order
//   mem_wr/addr/din         : registered BRAM port controls
//   mem_dout                : BRAM read data, one cycle after mem_addr
`timescale 1ns/1ps
module bram_port_ctrl
    import bram_port_ctrl_pkg::*;
#(
    parameter int DATA = DEFAULT_DATA,
    parameter int ADDR = DEFAULT_ADDR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output logic            init_busy,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [ADDR-1:0] req_addr,
    input  logic [DATA-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DATA-1:0] rsp_rdata,
    output logic            mem_wr,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_din,
    input  logic [DATA-1:0] mem_dout
);

    state_t           state_reg, state_next;
    logic [ADDR-1:0]  fill_addr_reg;
    logic [1:0]       inflight_reg;
    logic             rd_p1_reg;     // read address on the BRAM port
    logic             rd_p2_reg;     // read data on mem_dout
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic             accept;
    logic             rd_accept;
    logic             rsp_pop;
    logic             mem_wr_reg;
    logic [ADDR-1:0]  mem_addr_reg;
    logic [DATA-1:0]  mem_din_reg;

    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_wr;
    assign rsp_valid = (fifo_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign mem_wr    = mem_wr_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_din   = mem_din_reg;

    // Every in-flight read already owns a FIFO slot, so a push can never
    // find the FIFO full.
    assign credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_reg);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:  if (fill_addr_reg == '1) state_next = ST_RUN;
            ST_RUN:   if (clr) state_next = ST_DRAIN;
            ST_DRAIN: if (inflight_reg == '0) state_next = ST_INIT;
            default:  state_next = ST_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        init_busy = (state_reg != ST_RUN);
        req_ready = (state_reg == ST_RUN) && (credit_used < (CNT_W + 1)'(RSP_DEPTH));
    end

    // Fill address counter; wraps to zero after the last address and is
    // forced to zero while draining so the next fill starts at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_addr_reg <= '0;
        end else if (state_reg == ST_INIT) begin
            fill_addr_reg <= fill_addr_reg + 1'b1;
        end else if (state_reg == ST_DRAIN) begin
            fill_addr_reg <= '0;
        end
    end

    // Registered BRAM port. Idle cycles drop mem_wr but hold address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_din_reg  <= '0;
        end else if (state_reg == ST_INIT) begin
            mem_wr_reg   <= 1'b1;
            mem_addr_reg <= fill_addr_reg;
            mem_din_reg  <= '0;
        end else if (accept) begin
            mem_wr_reg   <= req_wr;
            mem_addr_reg <= req_addr;
            if (req_wr) begin
                mem_din_reg <= req_wdata;
            end
        end else begin
            mem_wr_reg <= 1'b0;
        end
    end

    // Read pipeline tracking and in-flight count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_p1_reg    <= 1'b0;
            rd_p2_reg    <= 1'b0;
            inflight_reg <= '0;
        end else begin
            rd_p1_reg <= rd_accept;
            rd_p2_reg <= rd_p1_reg;
            case ({rd_accept, rd_p2_reg})
                2'b10:   inflight_reg <= inflight_reg + 1'b1;
                2'b01:   inflight_reg <= inflight_reg - 1'b1;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    rsp_fifo #(
        .DATA (DATA)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_p2_reg),
        .push_data (mem_dout),
        .pop       (rsp_pop),
        .count     (fifo_count),
        .head_data (rsp_rdata)
    );

endmodule
